// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end that shares one sequential int_divider among N requesters.
// Optional feature macro DIV_ARBITER_DBZ_EN: zero divisors are answered locally (all-ones quotient, rsp_dbz).
module div_arbiter #(
    parameter int WIDTH = 12,
    parameter int N     = 4,
    localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_vld,
    input  logic [N*WIDTH-1:0]   req_dvd,
    input  logic [N*WIDTH-1:0]   req_dvs,
    output logic [N-1:0]         req_ack,
    output logic [N-1:0]         rsp_vld,
    output logic [WIDTH-1:0]     rsp_quo,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy,
`ifdef DIV_ARBITER_DBZ_EN
    output logic                 rsp_dbz,
`endif
    output logic                 div_cal,
    output logic [WIDTH-1:0]     div_dvd,
    output logic [WIDTH-1:0]     div_dvs,
    input  logic [WIDTH-1:0]     div_quo,
    input  logic                 div_rdy
);

    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [ID_W-1:0]   gid_q, gid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]  div_dvd_q, div_dvd_d;
    logic [WIDTH-1:0]  div_dvs_q, div_dvs_d;
    logic [WIDTH-1:0]  rsp_quo_q, rsp_quo_d;
    logic              div_cal_q, div_cal_d;
    logic [N-1:0]      rsp_vld_q, rsp_vld_d;
`ifdef DIV_ARBITER_DBZ_EN
    logic              dbz_q, dbz_d;
    logic              rsp_dbz_q, rsp_dbz_d;
`endif

    logic [WIDTH-1:0]  slot_dvd [N];
    logic [WIDTH-1:0]  slot_dvs [N];
    logic              grant_found;
    logic [ID_W-1:0]   grant_id;

    for (genvar gi = 0; gi < N; gi++) begin : g_slot
        assign slot_dvd[gi] = req_dvd[gi*WIDTH +: WIDTH];
        assign slot_dvs[gi] = req_dvs[gi*WIDTH +: WIDTH];
    end

    // First pending requester at or above the rr pointer, wrapping past N-1.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!grant_found && req_vld[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx[ID_W-1:0];
            end
        end
    end

    // Ack is combinational so a request seen in IDLE is captured on this very edge.
    always_comb begin
        req_ack = '0;
        if (rst && state_q == IDLE && grant_found) req_ack[grant_id] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gid_d     = gid_q;
        rsp_id_d  = rsp_id_q;
        div_dvd_d = div_dvd_q;
        div_dvs_d = div_dvs_q;
        rsp_quo_d = rsp_quo_q;
        div_cal_d = 1'b0;
        rsp_vld_d = '0;
`ifdef DIV_ARBITER_DBZ_EN
        dbz_d     = dbz_q;
        rsp_dbz_d = rsp_dbz_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    gid_d     = grant_id;
                    div_dvd_d = slot_dvd[grant_id];
                    div_dvs_d = slot_dvs[grant_id];
`ifdef DIV_ARBITER_DBZ_EN
                    dbz_d = (slot_dvs[grant_id] == '0);
                    if (slot_dvs[grant_id] == '0) begin
                        state_d = RESP;
                    end else begin
                        state_d   = ISSUE;
                        div_cal_d = 1'b1;
                    end
`else
                    state_d   = ISSUE;
                    div_cal_d = 1'b1;
`endif
                end
            end
            ISSUE: state_d = ARM;
            // The divider's ready is still left over from the previous job here.
            ARM:   state_d = WAIT;
            WAIT: begin
                if (div_rdy) state_d = RESP;
            end
            RESP: begin
`ifdef DIV_ARBITER_DBZ_EN
                rsp_quo_d = dbz_q ? '1 : div_quo;
                rsp_dbz_d = dbz_q;
`else
                rsp_quo_d = div_quo;
`endif
                rsp_id_d         = gid_q;
                rsp_vld_d[gid_q] = 1'b1;
                rr_d             = (gid_q == ID_W'(N - 1)) ? '0 : gid_q + 1'b1;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            gid_q     <= '0;
            rsp_id_q  <= '0;
            div_dvd_q <= '0;
            div_dvs_q <= '0;
            rsp_quo_q <= '0;
            div_cal_q <= 1'b0;
            rsp_vld_q <= '0;
`ifdef DIV_ARBITER_DBZ_EN
            dbz_q     <= 1'b0;
            rsp_dbz_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            gid_q     <= gid_d;
            rsp_id_q  <= rsp_id_d;
            div_dvd_q <= div_dvd_d;
            div_dvs_q <= div_dvs_d;
            rsp_quo_q <= rsp_quo_d;
            div_cal_q <= div_cal_d;
            rsp_vld_q <= rsp_vld_d;
`ifdef DIV_ARBITER_DBZ_EN
            dbz_q     <= dbz_d;
            rsp_dbz_q <= rsp_dbz_d;
`endif
        end
    end

    assign rsp_vld = rsp_vld_q;
    assign rsp_quo = rsp_quo_q;
    assign rsp_id  = rsp_id_q;
    assign busy    = (state_q != IDLE);
    assign div_cal = div_cal_q;
    assign div_dvd = div_dvd_q;
    assign div_dvs = div_dvs_q;
`ifdef DIV_ARBITER_DBZ_EN
    assign rsp_dbz = rsp_dbz_q;
`endif

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Round-robin scheduler that shares one int_divider instance among N requesters.
- Captures one requester's operands, pulses the divider's cal, waits for rdy, then returns the quotient to the granted requester.
- Sits between client blocks (rate/scale calculators) and a single divider, so the design needs only one sequential divider.

Parameters:
WIDTH, 12, operand/quotient width; must match the attached divider
N, 4, number of requesters (2..16)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (0 = reset)
req_vld  in  N  requester i has an operation pending; must hold operands stable until req_ack[i]
req_dvd  in  N*WIDTH  dividends, requester i at [i*WIDTH +: WIDTH]
req_dvs  in  N*WIDTH  divisors, same packing
req_ack  out  N  one-cycle pulse: operands of requester i captured
rsp_vld  out  N  one-cycle pulse: result for requester i valid on rsp_quo
rsp_quo  out  WIDTH  quotient of the most recent completed operation
rsp_id  out  $clog2(N)  index of requester owning rsp_quo
busy  out  1  controller not in IDLE
div_cal  out  1  to divider cal
div_dvd  out  WIDTH  to divider dvd; registered, stable from ISSUE until the next grant
div_dvs  out  WIDTH  to divider dvs; registered, same stability
div_quo  in  WIDTH  from divider quo
div_rdy  in  1  from divider rdy

Behaviour:
- Reset (rst=0 at posedge):
  - State IDLE; rr pointer 0.
  - req_ack, rsp_vld, div_cal = 0; rsp_quo, rsp_id, div_dvd, div_dvs = 0; busy = 0.
  - Reset mid-operation abandons the operation: no rsp_vld is ever issued for it, and the requester must re-request.
- States: IDLE, ISSUE, ARM, WAIT, RESP.
- IDLE:
  - If any req_vld, grant g = first set bit scanning from the rr pointer upward with wrap.
  - Register div_dvd/div_dvs from slot g; latch gid = g; pulse req_ack[g]; go to ISSUE.
  - Grant, capture and ack happen in the same cycle.
- ISSUE: div_cal = 1 for exactly one cycle; go to ARM.
- ARM:
  - div_rdy is ignored for one cycle, because the divider's ready is stale until it clears its internal flag.
  - Go to WAIT.
- WAIT: hold until div_rdy = 1, then go to RESP. No timeout.
- RESP:
  - rsp_quo <= div_quo; rsp_id <= gid; rsp_vld[gid] = 1 for one cycle.
  - rr pointer <= (gid+1) mod N; go to IDLE.
- Throughput:
  - One operation in flight at a time.
  - Minimum spacing between consecutive grants = (divider latency) + 4 cycles.
  - A request present in IDLE is acked the same cycle.
- Fairness: after serving gid, gid has lowest priority. With all N requesting, grants rotate 0,1,..,N-1,0.
- Simultaneous events:
  - req_vld[i] asserted in the RESP cycle is considered in the following IDLE cycle.
  - Deasserting req_vld before ack is legal; that request is simply never granted.
- rsp_quo/rsp_id hold their value until the next RESP.
- busy = (state != IDLE).
- No arithmetic is done in this block, except the rr pointer increment, which wraps modulo N (non-power-of-2 N must wrap correctly).

Optional Feature:
- Macro: DIV_ARBITER_DBZ_EN.
- Defined:
  - In IDLE, if the granted divisor is 0, skip ISSUE/ARM/WAIT and go directly to RESP.
  - rsp_quo = all ones; extra output rsp_dbz (1 bit) = 1 with that rsp_vld; div_cal is never pulsed.
  - rsp_dbz = 0 on all other responses and on reset.
- Not defined:
  - Port rsp_dbz is absent.
  - Divide-by-zero is forwarded to the divider like any operation, and rsp_quo is whatever the divider returns.

Test Plan:
- Reset with rst=0 for 3 cycles while req_vld=4'b1111 -> all outputs 0, no req_ack; after release, req_ack[0] is first.
- Single request: req_vld[2], dvd=100, dvs=7 -> req_ack[2] in the same cycle, one div_cal pulse, then rsp_vld[2] with rsp_quo=14 and rsp_id=2.
- All four requesting, dvd_i=1000+i, dvs_i=10 -> responses in order 0,1,2,3 with quotients 100,100,100,100. A second round starts at 0 again, with exactly one ack per requester per round.
- Pointer rotation: serve 1, then req_vld=4'b0011 -> requester 0 granted before 1; rsp_id sequence is 1,0,1.
- Reset asserted in WAIT -> no rsp_vld for the aborted op; a new request after release completes correctly (dvd=4095, dvs=1 -> 4095).
- With DIV_ARBITER_DBZ_EN: dvs=0, dvd=55 -> rsp_vld 2 cycles after ack, rsp_quo=12'hFFF, rsp_dbz=1, div_cal never asserted. Without the macro, div_cal pulses and the divider output is returned.
